serial_adder: RTL and testbench

Bit-serial two-operand adder built around one instance of the existing full_adder cell plus a registered carry. It accepts a WIDTH-bit operand pair through a valid/ready handshake and processes one bit per clock, LSB first. After WIDTH cycles it presents the sum, carry-out and signed overflow through a second valid/ready handshake. It is the sequential consumer of full_adder. It is the low-area alternative to the ripple add16 path for ALU-adjacent datapaths.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_full_adder.sv | 17 +
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial_adder slice.
//   HACK_WIDTH : default operand/result width
//   state_t    : serial_adder control states (encodings kept from the legacy header)
package serial_adder_pkg;

  localparam int unsigned HACK_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell, reused by serial_adder as its single arithmetic element.
// Ports:
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   cout      : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two-operand adder: one full_adder plus a registered carry, LSB first,
// one bit per clock. Operands enter through a valid/ready handshake; after WIDTH
// shift cycles the result is held under a second valid/ready handshake.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start_valid / start_ready  : operand handshake (ready only in IDLE)
//   a, b, cin                  : operands, sampled on the accept edge only
//   result_valid / result_ready: result handshake (valid only in DONE)
//   sum, cout, overflow        : a+b+cin mod 2^WIDTH, carry out, signed overflow;
//                                retained after the result is taken
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned       CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             carry_q,   carry_d;
  logic             cout_q,    cout_d;
  logic             msb_cin_q, msb_cin_d;
  logic [CW-1:0]    cnt_q,     cnt_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // The visible result lives in its own registers, separate from the working
  // shift register, so sum/cout/overflow stay frozen while the next operation
  // is shifting.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    msb_cin_d = msb_cin_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB
          msb_cin_d = carry_q;
          sum_d     = sum_sh_d;
          cout_d    = fa_cout;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      msb_cin_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      msb_cin_q <= msb_cin_d;
      cnt_q     <= cnt_d;
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign sum          = sum_q;
  assign cout         = cout_q;
  assign overflow     = msb_cin_q ^ cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=16): directed vectors with literal
// expectations plus a cycle-level behavioural model compared every cycle.
module tb_serial_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
    .overflow     (overflow)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain wide addition, overflow from operand/result signs.
  function automatic void calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                               output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] t;
    t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    s  = t[W-1:0];
    co = t[W];
    ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Transaction-level model: busy for W edges after an accept, then holds the
  // result until taken. Shown values are what sum/cout/overflow must present.
  bit           pend = 1'b0;
  int unsigned  edges = 0;
  logic [W-1:0] m_sum, sh_sum = '0;
  logic         m_cout, m_ovf, sh_cout = 1'b0, sh_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 1'b0; edges = 0;
      sh_sum = '0; sh_cout = 1'b0; sh_ovf = 1'b0;
    end else if (!pend) begin
      if (start_valid) begin
        calc(a, b, cin, m_sum, m_cout, m_ovf);
        pend = 1'b1; edges = 0;
      end
    end else if (edges < W) begin
      edges++;
      if (edges == W) begin
        sh_sum = m_sum; sh_cout = m_cout; sh_ovf = m_ovf;
      end
    end else if (result_ready) begin
      pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit done_m;
    if (rst_n) begin
      done_m = pend && (edges == W);
      check("model/start_ready", start_ready, !pend);
      check("model/result_valid", result_valid, done_m);
      if (!pend || done_m) begin
        check("model/sum", sum, sh_sum);
        check("model/cout", cout, sh_cout);
        check("model/overflow", overflow, sh_ovf);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input string nm, input int hold);
    int lat;
    @(negedge clk);
    check({nm, "/ready_before"}, start_ready, 1);
    a = ta; b = tb_; cin = tc; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0; a = ~ta; b = '0; cin = ~tc;
    check({nm, "/ready_after_accept"}, start_ready, 0);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 2 * W) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "/latency"}, lat, W);
    check({nm, "/sum"}, sum, es);
    check({nm, "/cout"}, cout, ec);
    check({nm, "/overflow"}, overflow, eo);
    if (hold > 0) begin
      start_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        check({nm, "/held_sum"}, sum, es);
        check({nm, "/held_valid"}, result_valid, 1);
        check({nm, "/held_not_ready"}, start_ready, 0);
      end
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0; start_valid = 1'b0;
    check({nm, "/idle_ready"}, start_ready, 1);
    check({nm, "/idle_valid"}, result_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rc, ec, eo;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/start_ready", start_ready, 1);
    check("reset/result_valid", result_valid, 0);
    check("reset/sum", sum, 0);
    check("reset/cout", cout, 0);
    check("reset/overflow", overflow, 0);
    rst_n = 1'b1;

    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "t1_1p1", 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "t2_wrap", 0);
    do_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "t2_cin", 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "t3_posovf", 0);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "t3_negovf", 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "allones_cin", 0);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "t4_backpressure", 5);

    // Reset after 7 shift edges: outputs must clear without waiting for a clock.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5/async_sum", sum, 0);
    check("t5/async_cout", cout, 0);
    check("t5/async_overflow", overflow, 0);
    check("t5/async_valid", result_valid, 0);
    check("t5/async_ready", start_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "t5_after_reset", 0);

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      calc(ra, rb, rc, es, ec, eo);
      do_op(ra, rb, rc, es, ec, eo, "t6_random", 0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
